hood_mode_ctrl: RTL



---
 rtl/hood_pkg.sv | 32 +++
 rtl/hood_sec_tick.sv | 23 ++
 rtl/hood_mode_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/hood_pkg.sv
// hood_pkg: shared mode encodings, fan level constants and default timing for the hood mode scheduler.
package hood_pkg;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      STANDBY = 3'd1,
      MENU    = 3'd2,
      LEVEL1  = 3'd3,
      LEVEL2  = 3'd4,
      LEVEL3  = 3'd5,
      RETURN  = 3'd6,
      CLEAN   = 3'd7
   } mode_t;

   localparam logic [1:0] FAN_OFF  = 2'd0;
   localparam logic [1:0] FAN_LOW  = 2'd1;
   localparam logic [1:0] FAN_MID  = 2'd2;
   localparam logic [1:0] FAN_HIGH = 2'd3;

   localparam int DEF_SECOND      = 100_000_000;
   localparam int DEF_L3_TIME     = 60;
   localparam int DEF_RETURN_TIME = 60;
   localparam int DEF_CLEAN_TIME  = 180;
   localparam int DEF_REMIND_SEC  = 36000;

   function automatic logic [1:0] fan_of(input mode_t m);
      return (m == LEVEL1) ? FAN_LOW :
             (m == LEVEL2) ? FAN_MID :
             (m == LEVEL3 || m == RETURN) ? FAN_HIGH : FAN_OFF;
   endfunction

endpackage

// File: rtl/hood_sec_tick.sv
// hood_sec_tick: one-second prescaler; tick on the terminal count, restartable by clr.
module hood_sec_tick #(
   parameter int SECOND = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = (SECOND > 1) ? $clog2(SECOND) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(SECOND - 1));

   always_ff @(posedge clk or negedge rst)
      if (!rst)
         cnt <= '0;
      else
         cnt <= (clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood fan mode scheduler with timed level-3, return and self-clean states,
// countdown display value and accumulated run time with cleaning reminder.
module hood_mode_ctrl
   import hood_pkg::*;
#(
   parameter int SECOND      = DEF_SECOND,
   parameter int L3_TIME     = DEF_L3_TIME,
   parameter int RETURN_TIME = DEF_RETURN_TIME,
   parameter int CLEAN_TIME  = DEF_CLEAN_TIME,
   parameter int REMIND_SEC  = DEF_REMIND_SEC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        machine_state,
   input  logic        menu_pulse,
   input  logic        lvl1_pulse,
   input  logic        lvl2_pulse,
   input  logic        lvl3_pulse,
   input  logic        clean_pulse,
   output logic [2:0]  mode,
   output logic [1:0]  fan_level,
   output logic [7:0]  countdown_sec,
   output logic        hurricane_used,
   output logic [16:0] usage_sec,
   output logic        clean_reminder
);

   mode_t       state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        hurry, hurry_n;
   logic [16:0] usage, usage_n;
   logic        tick, clr, timed, last;

   hood_sec_tick #(.SECOND(SECOND)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   assign mode           = state;
   assign fan_level      = fan_of(state);
   assign countdown_sec  = cnt;
   assign hurricane_used = hurry;
   assign usage_sec      = usage;
   assign clean_reminder = (usage >= 17'(REMIND_SEC));
   assign timed          = (state == LEVEL3) || (state == RETURN) || (state == CLEAN);
   assign last           = tick && (cnt == 8'd1);
   // Restarting the prescaler on entry makes every timed state last exactly N seconds.
   assign clr            = (state_n != state);

   always_comb begin
      state_n = state;
      cnt_n   = (timed && tick && cnt != 8'd0) ? cnt - 8'd1 : cnt;
      hurry_n = hurry;
      usage_n = (tick && fan_level != FAN_OFF && usage != '1) ? usage + 17'd1 : usage;
      if (!machine_state) begin
         state_n = OFF;
         cnt_n   = 8'd0;
         hurry_n = 1'b0;
      end else begin
         case (state)
            OFF:     state_n = STANDBY;
            STANDBY: state_n = menu_pulse ? MENU : STANDBY;
            MENU: begin
               if (menu_pulse)
                  state_n = STANDBY;
               else if (lvl3_pulse && !hurry) begin
                  state_n = LEVEL3;
                  cnt_n   = 8'(L3_TIME);
                  hurry_n = 1'b1;
               end else if (lvl2_pulse)
                  state_n = LEVEL2;
               else if (lvl1_pulse)
                  state_n = LEVEL1;
               else if (clean_pulse) begin
                  state_n = CLEAN;
                  cnt_n   = 8'(CLEAN_TIME);
               end
            end
            LEVEL1, LEVEL2:
               state_n = menu_pulse ? STANDBY : lvl2_pulse ? LEVEL2 : lvl1_pulse ? LEVEL1 : state;
            LEVEL3: begin
               if (menu_pulse) begin
                  state_n = RETURN;
                  cnt_n   = 8'(RETURN_TIME);
               end else if (last)
                  state_n = LEVEL2;
            end
            RETURN:  state_n = last ? STANDBY : RETURN;
            CLEAN: begin
               if (last) begin
                  state_n = STANDBY;
                  usage_n = '0;
               end
            end
            default: state_n = OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= OFF;
         cnt   <= '0;
         hurry <= 1'b0;
         usage <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hurry <= hurry_n;
         usage <= usage_n;
      end

endmodule
